// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: pointer/count width
// derivation and parameter legality checks used at elaboration.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit af_ok(input int depth, input int af);
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit ae_ok(input int depth, input int ae);
    return (ae >= 0) && (ae <= depth - 1);
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port and one
// registered read port (rdata holds unless re; cleared by rst_n).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Same-edge write to raddr returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with count, almost flags, error
// pulses and flush. Ports: clk/clr_n, flush, din/write, read/dout,
// empty/full/almost_*, count, overflow/underflow.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        din,
  input  logic                    write,
  input  logic                    read,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("fifo_param: DEPTH must be a power of two >= 2");
  end
  if (!af_ok(DEPTH, AF_LEVEL)) begin : g_bad_af
    $error("fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (!ae_ok(DEPTH, AE_LEVEL)) begin : g_bad_ae
    $error("fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_ok, rd_ok;
  fifo_flags_t      flags;

  always_comb begin
    flags              = '0;
    flags.empty        = (count_q == '0);
    flags.full         = (count_q == DEPTH_C);
    flags.almost_empty = (count_q <= AE_C);
    flags.almost_full  = (count_q >= AF_C);
  end

  // A read on a full FIFO frees a slot in the same edge; a write on
  // an empty FIFO never satisfies a same-cycle read.
  assign wr_ok = write & (~flags.full | read) & ~flush;
  assign rd_ok = read & ~flags.empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case (1'b1)
        (wr_ok & ~rd_ok): count_d = count_q + CNT_W'(1);
        (rd_ok & ~wr_ok): count_d = count_q - CNT_W'(1);
        default:          count_d = count_q;
      endcase
    end
  end

  always_comb begin
    ovf_d = write & flags.full & ~read & ~flush;
    udf_d = read & flags.empty & ~flush;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (clr_n),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (rd_ok),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

  assign empty        = flags.empty;
  assign full         = flags.full;
  assign almost_empty = flags.almost_empty;
  assign almost_full  = flags.almost_full;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (4 x 8, AF=6, AE=2) against a
// queue-based reference model; directed steps then random traffic.
module tb_fifo_param;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] din = '0;
  logic         write = 1'b0;
  logic         read = 1'b0;
  logic [W-1:0] dout;
  logic         empty, full, almost_empty, almost_full;
  logic [3:0]   count;
  logic         overflow, underflow;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  bit           m_ovf = 0;
  bit           m_udf = 0;

  fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .clr_n(clr_n), .flush(flush), .din(din),
    .write(write), .read(read), .dout(dout), .empty(empty),
    .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 0;
    m_udf  = 0;
  endtask

  task automatic model_edge(bit w, bit r, bit f, logic [W-1:0] d);
    int n;
    n = q.size();
    if (f) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      m_ovf = w && (n == D) && !r;
      m_udf = r && (n == 0);
      if (r && n > 0) m_dout = q.pop_front();
      if (w && (n < D || r)) q.push_back(d);
    end
  endtask

  task automatic check_all(string ctx);
    int n;
    n = q.size();
    chk({ctx, ".count"}, 32'(count), 32'(n));
    chk({ctx, ".empty"}, 32'(empty), 32'(n == 0));
    chk({ctx, ".full"}, 32'(full), 32'(n == D));
    chk({ctx, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
    chk({ctx, ".afull"}, 32'(almost_full), 32'(n >= AF));
    chk({ctx, ".dout"}, 32'(dout), 32'(m_dout));
    chk({ctx, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({ctx, ".udf"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic step(string ctx, bit w, bit r, bit f,
                      logic [W-1:0] d);
    @(negedge clk);
    write = w;
    read  = r;
    flush = f;
    din   = d;
    @(posedge clk);
    #1;
    model_edge(w, r, f, d);
    check_all(ctx);
  endtask

  initial begin
    model_reset();
    // reset held with write asserted
    write = 1'b1;
    din   = 4'h5;
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    @(negedge clk);
    clr_n = 1'b1;
    write = 1'b0;

    // fill 1..8 and drain
    for (int i = 1; i <= 8; i++) step("fill", 1, 0, 0, 4'(i));
    for (int i = 0; i < 8; i++) step("drain", 0, 1, 0, '0);

    // overflow at full, then write+read at full
    for (int i = 0; i < 8; i++) step("fill2", 1, 0, 0, 4'(8 - i));
    step("ovf", 1, 0, 0, 4'hF);
    step("ovf_gone", 0, 0, 0, '0);
    step("wr_rd_full", 1, 1, 0, 4'hA);
    for (int i = 0; i < 8; i++) step("drain2", 0, 1, 0, '0);

    // underflow, and write+read when empty
    step("udf", 0, 1, 0, '0);
    step("wr_rd_empty", 1, 1, 0, 4'hA);
    step("rd_a", 0, 1, 0, '0);

    // wrap-around at steady count 3
    for (int i = 0; i < 3; i++) step("wrap_pre", 1, 0, 0, 4'($urandom));
    for (int i = 0; i < 20; i++) step("wrap", 1, 1, 0, 4'($urandom));
    for (int i = 0; i < 3; i++) step("wrap_post", 0, 1, 0, '0);

    // flush with concurrent write
    for (int i = 0; i < 5; i++) step("pre_flush", 1, 0, 0, 4'(i + 3));
    step("pre_flush_rd", 0, 1, 0, '0);
    step("pre_flush_wr", 1, 0, 0, 4'hC);
    step("flush", 1, 0, 1, 4'h9);
    step("post_flush_wr", 1, 0, 0, 4'h7);
    step("post_flush_rd", 0, 1, 0, '0);

    // asynchronous reset mid-run at count 5
    for (int i = 0; i < 6; i++) step("pre_arst", 1, 0, 0, 4'(i + 9));
    step("pre_arst_rd", 0, 1, 0, '0);
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
    #2;
    clr_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(posedge clk);
    #1;
    check_all("arst_hold");
    @(negedge clk);
    clr_n = 1'b1;

    // random traffic, write-biased then read-biased then mixed
    for (int i = 0; i < 400; i++) begin
      bit w, r, f;
      int pw;
      pw = (i < 130) ? 80 : (i < 260) ? 25 : 50;
      w  = ($urandom_range(0, 99) < pw);
      r  = ($urandom_range(0, 99) < (100 - pw));
      f  = ($urandom_range(0, 31) == 0);
      step("rand", w, r, f, 4'($urandom));
    end
    while (q.size() > 0) step("final_drain", 0, 1, 0, '0);
    step("final_udf", 0, 1, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
